// File: rtl/gates_bist_ctrl.sv
// gates_bist_ctrl: built-in self-test sequencer for the 7-function two-input
// gate unit. Sweeps the four (a,b) vectors LOOP_COUNT times, holds each for
// SETTLE_CYCLES cycles, checks y_i against a hardwired golden truth table in a
// one-cycle CHECK state, and reports err_cnt / fail_mask / pass with a done pulse.
//
// Optional build feature: define GATES_BIST_STOP_ON_FAIL_EN to end the run at
// the first mismatching vector instead of checking every vector.
module gates_bist_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int LOOP_COUNT    = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             a_o,
    output logic             b_o,
    input  logic [6:0]       y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [6:0]       fail_mask
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LCW = (LOOP_COUNT > 1) ? $clog2(LOOP_COUNT) : 1;

    localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [LCW-1:0]   LOOP_LAST   = LCW'(LOOP_COUNT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    // Expected gate-unit result for input vector {a,b}:
    // bit order [0]and [1]or [2]not(a) [3]xor [4]nand [5]nor [6]xnor.
    function automatic logic [6:0] golden_f(input logic [1:0] vec);
        logic [6:0] g;
        case (vec)
            2'b00:   g = 7'h74;
            2'b01:   g = 7'h1E;
            2'b10:   g = 7'h1A;
            2'b11:   g = 7'h43;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    logic [1:0]       state_r,  state_s;
    logic [1:0]       idx_r,    idx_s;
    logic [SCW-1:0]   settle_r, settle_s;
    logic [LCW-1:0]   sweep_r,  sweep_s;
    logic [1:0]       vec_r,    vec_s;
    logic             busy_r,   busy_s;
    logic             done_r,   done_s;
    logic             pass_r,   pass_s;
    logic [ERR_W-1:0] err_r,    err_s;
    logic [6:0]       mask_r,   mask_s;

    logic [6:0]       diff_s;
    logic             mismatch_s;
    logic             last_s;
    logic             stop_s;
    logic [ERR_W-1:0] err_inc_s;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        settle_s   = settle_r;
        sweep_s    = sweep_r;
        vec_s      = vec_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        pass_s     = pass_r;
        err_s      = err_r;
        mask_s     = mask_r;

        diff_s     = y_i ^ golden_f(idx_r);
        mismatch_s = |diff_s;
        last_s     = (idx_r == 2'b11) && (sweep_r == LOOP_LAST);
        err_inc_s  = (err_r == ERR_MAX) ? err_r : (err_r + ERR_W'(1));
`ifdef GATES_BIST_STOP_ON_FAIL_EN
        stop_s     = last_s || mismatch_s;
`else
        stop_s     = last_s;
`endif

        if ((state_r != ST_IDLE) && abort) begin
            // Cancel: results so far stay visible, no done pulse.
            state_s  = ST_IDLE;
            busy_s   = 1'b0;
            vec_s    = 2'b00;
            pass_s   = 1'b0;
            idx_s    = 2'b00;
            settle_s = '0;
            sweep_s  = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s  = ST_SETTLE;
                        busy_s   = 1'b1;
                        vec_s    = 2'b00;
                        err_s    = '0;
                        mask_s   = 7'h00;
                        pass_s   = 1'b0;
                        idx_s    = 2'b00;
                        settle_s = '0;
                        sweep_s  = '0;
                    end else begin
                        state_s  = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_r == SETTLE_LAST) begin
                        settle_s = '0;
                        state_s  = ST_CHECK;
                    end else begin
                        settle_s = settle_r + SCW'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch_s) begin
                        err_s  = err_inc_s;
                        mask_s = mask_r | diff_s;
                    end else begin
                        err_s  = err_r;
                    end
                    if (stop_s) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        vec_s   = 2'b00;
                        // Saturating counter never wraps, so zero after this
                        // check means zero before it and no new mismatch.
                        pass_s  = (err_r == '0) && !mismatch_s;
                        idx_s   = 2'b00;
                        sweep_s = '0;
                    end else begin
                        state_s = ST_SETTLE;
                        idx_s   = idx_r + 2'd1;
                        vec_s   = idx_r + 2'd1;
                        if (idx_r == 2'b11) begin
                            sweep_s = sweep_r + LCW'(1);
                        end else begin
                            sweep_s = sweep_r;
                        end
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s  = ST_IDLE;
                    busy_s   = 1'b0;
                    vec_s    = 2'b00;
                    idx_s    = 2'b00;
                    settle_s = '0;
                    sweep_s  = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            idx_r    <= 2'b00;
            settle_r <= '0;
            sweep_r  <= '0;
            vec_r    <= 2'b00;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            err_r    <= '0;
            mask_r   <= 7'h00;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            settle_r <= settle_s;
            sweep_r  <= sweep_s;
            vec_r    <= vec_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            pass_r   <= pass_s;
            err_r    <= err_s;
            mask_r   <= mask_s;
        end
    end

    assign a_o       = vec_r[1];
    assign b_o       = vec_r[0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_cnt   = err_r;
    assign fail_mask = mask_r;

endmodule

// File: tb/tb_gates_bist_ctrl.sv
// Self-checking bench for gates_bist_ctrl. Three instances: defaults driven by
// a behavioural gate model (optionally with xor stuck at 0), and two with
// y_i tied to zero (SETTLE_CYCLES=3, LOOP_COUNT=2, ERR_W 4 and 2).
module tb_gates_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0: defaults, behavioural gate model
    logic       start0 = 1'b0, abort0 = 1'b0;
    logic       a0, b0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [6:0] mask0, y0, good0;
    int         fault_mode = 0;

    assign good0 = {~(a0 ^ b0), ~(a0 | b0), ~(a0 & b0), a0 ^ b0, ~a0, a0 | b0, a0 & b0};
    assign y0    = (fault_mode == 1) ? (good0 & 7'h77) : good0;

    gates_bist_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .a_o(a0), .b_o(b0), .y_i(y0), .busy(busy0), .done(done0),
        .pass(pass0), .err_cnt(err0), .fail_mask(mask0)
    );

    // Instance 1: y_i tied to zero, longer settle, two sweeps
    logic       start1 = 1'b0;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [6:0] mask1;

    gates_bist_ctrl #(.SETTLE_CYCLES(3), .LOOP_COUNT(2), .ERR_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
        .a_o(a1), .b_o(b1), .y_i(7'h00), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1), .fail_mask(mask1)
    );

    // Instance 2: as instance 1 with a 2-bit saturating counter
    logic       start2 = 1'b0;
    logic       a2, b2, busy2, done2, pass2;
    logic [1:0] err2;
    logic [6:0] mask2;

    gates_bist_ctrl #(.SETTLE_CYCLES(3), .LOOP_COUNT(2), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .a_o(a2), .b_o(b2), .y_i(7'h00), .busy(busy2), .done(done2),
        .pass(pass2), .err_cnt(err2), .fail_mask(mask2)
    );

    // Observation mux onto the instance currently under test
    int         cur = 0;
    logic       busy_m, done_m, pass_m;
    logic [1:0] ab_m;
    logic [7:0] err_m;
    logic [6:0] mask_m;
    always_comb begin
        busy_m = busy0; done_m = done0; pass_m = pass0;
        ab_m = {a0, b0}; err_m = {4'b0000, err0}; mask_m = mask0;
        case (cur)
            1: begin
                busy_m = busy1; done_m = done1; pass_m = pass1;
                ab_m = {a1, b1}; err_m = {4'b0000, err1}; mask_m = mask1;
            end
            2: begin
                busy_m = busy2; done_m = done2; pass_m = pass2;
                ab_m = {a2, b2}; err_m = {6'b000000, err2}; mask_m = mask2;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            1:       start1 = v;
            2:       start2 = v;
            default: start0 = v;
        endcase
    endtask

    logic [1:0] trace [64];

    // Pulse start on instance sel and observe a fixed 60-cycle window.
    // repulse >= 0 raises start again for one cycle at that window index.
    task automatic run(input int sel, input int repulse,
                       output int nbusy, output int done_at, output int ndone);
        cur = sel;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        nbusy = 0; ndone = 0; done_at = -1;
        for (int i = 0; i < 60; i++) begin
            if (busy_m) begin
                if (nbusy < 64) trace[nbusy] = ab_m;
                nbusy++;
            end
            if (done_m) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
            set_start(sel, (i == repulse) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
        end
        set_start(sel, 1'b0);
    endtask

    typedef struct {
        int         sel;
        int         fault;
        int         exp_busy;
        int         exp_err;
        logic [6:0] exp_mask;
        logic       exp_pass;
        bit         chk_trace;
    } vec_t;

    vec_t tbl [4];
    int   nb, da, nd;

    initial begin
        // Expected results per run
        tbl[0] = '{0, 0, 8, 0, 7'h00, 1'b1, 1'b1};
`ifdef GATES_BIST_STOP_ON_FAIL_EN
        tbl[1] = '{0, 1, 4, 1, 7'h08, 1'b0, 1'b0};
        tbl[2] = '{1, 0, 4, 1, 7'h74, 1'b0, 1'b0};
        tbl[3] = '{2, 0, 4, 1, 7'h74, 1'b0, 1'b0};
`else
        tbl[1] = '{0, 1, 8, 2, 7'h08, 1'b0, 1'b0};
        tbl[2] = '{1, 0, 32, 8, 7'h7F, 1'b0, 1'b0};
        tbl[3] = '{2, 0, 32, 3, 7'h7F, 1'b0, 1'b0};
`endif

        // Reset state
        #2;
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_ab", {a0, b0}, 2'b00);
        chk("rst_pass", pass0, 1'b0);
        chk("rst_err", err0, 4'h0);
        chk("rst_mask", mask0, 7'h00);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven full runs
        foreach (tbl[r]) begin
            fault_mode = tbl[r].fault;
            run(tbl[r].sel, -1, nb, da, nd);
            chk($sformatf("row%0d_busy_cycles", r), nb, tbl[r].exp_busy);
            chk($sformatf("row%0d_done_at", r), da, tbl[r].exp_busy);
            chk($sformatf("row%0d_done_count", r), nd, 1);
            chk($sformatf("row%0d_err_cnt", r), err_m, tbl[r].exp_err);
            chk($sformatf("row%0d_fail_mask", r), mask_m, tbl[r].exp_mask);
            chk($sformatf("row%0d_pass", r), pass_m, tbl[r].exp_pass);
            if (tbl[r].chk_trace) begin
                for (int k = 0; k < 8; k++)
                    chk($sformatf("row%0d_ab_cycle%0d", r, k), trace[k], k / 2);
            end
        end

        // start re-pulsed during busy cycle 3 is ignored
        cur = 0; fault_mode = 0;
        run(0, 2, nb, da, nd);
        chk("repulse_busy_cycles", nb, 8);
        chk("repulse_done_count", nd, 1);
        chk("repulse_pass", pass0, 1'b1);
        chk("repulse_ab_cycle6", trace[6], 2'b11);

        // abort while vector 10 is applied
`ifdef GATES_BIST_STOP_ON_FAIL_EN
        fault_mode = 0;
`else
        fault_mode = 1;
`endif
        start0 = 1'b1; @(posedge clk); #1; start0 = 1'b0;
        for (int i = 0; i < 20 && ({a0, b0} != 2'b10); i++) begin
            @(posedge clk); #1;
        end
        chk("abort_reach_vec10", {a0, b0}, 2'b10);
        abort0 = 1'b1; @(posedge clk); #1; abort0 = 1'b0;
        chk("abort_busy", busy0, 1'b0);
        chk("abort_ab", {a0, b0}, 2'b00);
        chk("abort_pass", pass0, 1'b0);
`ifdef GATES_BIST_STOP_ON_FAIL_EN
        chk("abort_err_frozen", err0, 4'h0);
        chk("abort_mask_frozen", mask0, 7'h00);
`else
        chk("abort_err_frozen", err0, 4'h1);
        chk("abort_mask_frozen", mask0, 7'h08);
`endif
        nd = 0; nb = 0;
        for (int i = 0; i < 10; i++) begin
            if (done0) nd++;
            if (busy0) nb++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_stays_idle", nb, 0);

        // clean run after the abort
        fault_mode = 0;
        run(0, -1, nb, da, nd);
        chk("post_abort_busy_cycles", nb, 8);
        chk("post_abort_done_count", nd, 1);
        chk("post_abort_pass", pass0, 1'b1);
        chk("post_abort_err", err0, 4'h0);

        // abort in IDLE has no effect
        abort0 = 1'b1; @(posedge clk); #1; abort0 = 1'b0;
        chk("idle_abort_busy", busy0, 1'b0);
        chk("idle_abort_pass_held", pass0, 1'b1);

        // simultaneous start and abort in IDLE: start wins
        start0 = 1'b1; abort0 = 1'b1; @(posedge clk); #1;
        start0 = 1'b0; abort0 = 1'b0;
        chk("start_abort_busy", busy0, 1'b1);
        chk("start_abort_pass_cleared", pass0, 1'b0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            if (done0) nd++;
            @(posedge clk); #1;
        end
        chk("start_abort_done_count", nd, 1);
        chk("start_abort_pass", pass0, 1'b1);

        // asynchronous reset mid-SETTLE
        start0 = 1'b1; @(posedge clk); #1; start0 = 1'b0;
        for (int i = 0; i < 20 && ({a0, b0} != 2'b01); i++) begin
            @(posedge clk); #1;
        end
        chk("mid_run_busy", busy0, 1'b1);
        chk("mid_run_ab", {a0, b0}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy0, 1'b0);
        chk("async_rst_ab", {a0, b0}, 2'b00);
        chk("async_rst_done", done0, 1'b0);
        chk("async_rst_err", err0, 4'h0);
        chk("async_rst_mask", mask0, 7'h00);
        @(negedge clk); rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done0) nd++;
        end
        chk("async_rst_no_done", nd, 0);
        run(0, -1, nb, da, nd);
        chk("post_rst_busy_cycles", nb, 8);
        chk("post_rst_done_count", nd, 1);
        chk("post_rst_pass", pass0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
